mode_display_scanner: RTL and testbench

//  Time-multiplexed NUM_DIGITS-digit 7-seg driver for the drive-mode/status display.

---
 rtl/mode_display_pkg.sv | 28 ++
 rtl/mode_display_scanner_if.sv | 22 ++
 rtl/sym_seven_seg_decode.sv | 31 +++
 rtl/mode_display_scanner.sv | 131 +++++++++++++
 tb/tb_mode_display_scanner.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mode_display_pkg.sv
// Symbol codes and active-low {g,f,e,d,c,b,a} segment patterns for the mode/status display.
package mode_display_pkg;

  localparam logic [3:0] SYM_P     = 4'hA;
  localparam logic [3:0] SYM_R     = 4'hB;
  localparam logic [3:0] SYM_D     = 4'hC;
  localparam logic [3:0] SYM_N     = 4'hD;
  localparam logic [3:0] SYM_DASH  = 4'hE;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  localparam logic [6:0] SEG_OFF  = 7'b111_1111;
  localparam logic [6:0] SEG_0    = 7'b100_0000;
  localparam logic [6:0] SEG_1    = 7'b111_1001;
  localparam logic [6:0] SEG_2    = 7'b010_0100;
  localparam logic [6:0] SEG_3    = 7'b011_0000;
  localparam logic [6:0] SEG_4    = 7'b001_1001;
  localparam logic [6:0] SEG_5    = 7'b001_0010;
  localparam logic [6:0] SEG_6    = 7'b000_0010;
  localparam logic [6:0] SEG_7    = 7'b111_1000;
  localparam logic [6:0] SEG_8    = 7'b000_0000;
  localparam logic [6:0] SEG_9    = 7'b001_0000;
  localparam logic [6:0] SEG_P    = 7'b000_1100;
  localparam logic [6:0] SEG_R    = 7'b010_1111;
  localparam logic [6:0] SEG_D    = 7'b010_0001;
  localparam logic [6:0] SEG_N    = 7'b010_1011;
  localparam logic [6:0] SEG_DASH = 7'b011_1111;

endpackage

// File: rtl/mode_display_scanner_if.sv
// Symbol/control inputs from the mode logic and the board-facing segment/anode pins.
interface mode_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   code_in;
  logic                      blank_lz;
  logic [NUM_DIGITS-1:0]     blink_en;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_tick;

  modport master (
    output load, code_in, blank_lz, blink_en,
    input  seg, an, frame_tick
  );

  modport slave (
    input  load, code_in, blank_lz, blink_en,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/sym_seven_seg_decode.sv
// Combinational 4-bit symbol code to active-low 7-segment pattern; zero latency.
module sym_seven_seg_decode
  import mode_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      4'h0:      pattern = SEG_0;
      4'h1:      pattern = SEG_1;
      4'h2:      pattern = SEG_2;
      4'h3:      pattern = SEG_3;
      4'h4:      pattern = SEG_4;
      4'h5:      pattern = SEG_5;
      4'h6:      pattern = SEG_6;
      4'h7:      pattern = SEG_7;
      4'h8:      pattern = SEG_8;
      4'h9:      pattern = SEG_9;
      SYM_P:     pattern = SEG_P;
      SYM_R:     pattern = SEG_R;
      SYM_D:     pattern = SEG_D;
      SYM_N:     pattern = SEG_N;
      SYM_DASH:  pattern = SEG_DASH;
      default:   pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mode_display_scanner.sv
// Multiplexed 7-seg scanner with frame-synchronous display update, leading-zero blanking and blink.
// seg/an are registered: they show the digit selected on the previous clock.
module mode_display_scanner
  import mode_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter int AN_ACT_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mode_display_scanner_if.slave  bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           digit_idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic                    wrap_q;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] display;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    tick_q;

  logic                    slot_last;
  logic                    frame_boundary;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic [3:0]              cur_code;
  logic                    cur_blank;
  logic [3:0]              shown_code;
  logic [6:0]              pattern;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS-1:0]   an_on;

  assign slot_last      = (slot_cnt == SLOT_LAST);
  assign frame_boundary = slot_last && (digit_idx == DIGIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= frame_boundary;
      if (!slot_last) begin
        slot_cnt <= slot_cnt + 1'b1;
      end else begin
        slot_cnt <= '0;
        if (digit_idx != DIGIT_LAST) begin
          digit_idx <= digit_idx + 1'b1;
        end else begin
          digit_idx <= '0;
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Display only changes at the frame boundary so a frame never mixes old and new codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '1;
      display <= '1;
    end else begin
      if (bus.load) shadow <= bus.code_in;
      if (frame_boundary) display <= bus.load ? bus.code_in : shadow;
    end
  end

  // Zero run starts at the MSD; any non-zero code (including A-F) ends it. Digit 0 is exempt.
  always_comb begin
    lz_blank = '0;
    zero_run = bus.blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (display[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  assign cur_code   = display[{digit_idx, 2'b00} +: 4];
  assign cur_blank  = lz_blank[digit_idx] | (blink_phase & bus.blink_en[digit_idx]);
  assign shown_code = cur_blank ? SYM_BLANK : cur_code;
  assign an_sel     = NUM_DIGITS'(1) << digit_idx;
  assign an_on      = (AN_ACT_LOW != 0) ? ~an_sel : an_sel;

  sym_seven_seg_decode u_decode (
    .code    (shown_code),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap_q;
      if (slot_cnt == '0) begin
        seg_q <= SEG_OFF;
        an_q  <= AN_OFF;
      end else begin
        seg_q <= pattern;
        an_q  <= an_on;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_mode_display_scanner.sv
// Directed bench for mode_display_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, active-low anodes.
module tb_mode_display_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   evals = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mode_display_scanner_if #(.NUM_DIGITS(4)) bus ();

  mode_display_scanner #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLINK_DIV  (2),
    .AN_ACT_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    evals++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (bus.frame_tick !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk({tag, " frame_tick"}, {7'd0, bus.frame_tick}, 8'd1);
  endtask

  task automatic load_now(input logic [15:0] val);
    bus.load    = 1'b1;
    bus.code_in = val;
    step(1);
    bus.load    = 1'b0;
  endtask

  // Starts on the frame_tick cycle: one dark cycle then three lit cycles per digit, digit 0 first.
  task automatic check_frame(input string tag,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
    logic [6:0] exp_d [4];
    logic [3:0] onehot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    for (int c = 0; c < 16; c++) begin
      onehot  = 4'b0001 << (c / 4);
      exp_an  = (c % 4 == 0) ? 4'hF : ~onehot;
      exp_seg = (c % 4 == 0) ? 7'h7F : exp_d[c / 4];
      chk($sformatf("%s an c%0d", tag, c), {4'd0, bus.an}, {4'd0, exp_an});
      chk($sformatf("%s seg c%0d", tag, c), {1'b0, bus.seg}, {1'b0, exp_seg});
      chk($sformatf("%s tick c%0d", tag, c), {7'd0, bus.frame_tick}, {7'd0, (c == 0)});
      if (c == lc1) begin
        bus.load = 1'b1; bus.code_in = lv1;
      end else if (c == lc2) begin
        bus.load = 1'b1; bus.code_in = lv2;
      end else begin
        bus.load = 1'b0;
      end
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load     = 1'b0;
    bus.code_in  = 16'h0000;
    bus.blank_lz = 1'b0;
    bus.blink_en = 4'b0000;

    step(3);
    chk("rst seg", {1'b0, bus.seg}, 8'h7F);
    chk("rst an", {4'd0, bus.an}, 8'h0F);
    chk("rst tick", {7'd0, bus.frame_tick}, 8'h00);
    reset = 1'b0;
    step(1);
    chk("rel dark an", {4'd0, bus.an}, 8'h0F);
    step(1);
    chk("rel first an", {4'd0, bus.an}, 8'h0E);
    chk("rel first seg", {1'b0, bus.seg}, 8'h7F);

    wait_tick("t0");
    check_frame("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0, -1, 16'h0);

    load_now(16'hABC0);
    wait_tick("t_abc0");
    check_frame("abc0", 7'h40, 7'h21, 7'h2F, 7'h0C, -1, 16'h0, -1, 16'h0);

    bus.blank_lz = 1'b1;
    load_now(16'h0005);
    wait_tick("t_0005");
    check_frame("lz0005", 7'h12, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0, -1, 16'h0);

    load_now(16'h0000);
    wait_tick("t_0000");
    check_frame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0, -1, 16'h0);

    load_now(16'h0A05);
    wait_tick("t_0a05");
    check_frame("lz0a05", 7'h12, 7'h40, 7'h0C, 7'h7F, -1, 16'h0, -1, 16'h0);

    bus.blank_lz = 1'b0;
    load_now(16'h3333);
    wait_tick("t_3333");
    check_frame("midload", 7'h30, 7'h30, 7'h30, 7'h30, 5, 16'h1111, 9, 16'h2222);
    check_frame("next2222", 7'h24, 7'h24, 7'h24, 7'h24, 14, 16'h4567, -1, 16'h0);
    check_frame("coinc4567", 7'h78, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);

    // Pending shadow load, then reset during slot 2 of digit 2.
    step(3);
    load_now(16'h8888);
    step(5);
    reset = 1'b1;
    step(1);
    chk("midrst seg", {1'b0, bus.seg}, 8'h7F);
    chk("midrst an", {4'd0, bus.an}, 8'h0F);
    chk("midrst tick", {7'd0, bus.frame_tick}, 8'h00);
    reset = 1'b0;
    step(1);
    chk("midrst dark an", {4'd0, bus.an}, 8'h0F);
    step(1);
    chk("midrst d0 an", {4'd0, bus.an}, 8'h0E);
    chk("midrst d0 seg", {1'b0, bus.seg}, 8'h7F);

    bus.blink_en = 4'b0001;
    wait_tick("t_postrst");
    check_frame("postrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2, 16'h4567, -1, 16'h0);
    check_frame("blink f2", 7'h7F, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);
    check_frame("blink f3", 7'h7F, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);
    check_frame("blink f4", 7'h78, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);
    check_frame("blink f5", 7'h78, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);
    check_frame("blink f6", 7'h7F, 7'h02, 7'h12, 7'h19, -1, 16'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
